// File: rtl/ikbd_uart.sv
// ikbd_uart: keyboard-controller end of the IKBD serial link.
// Full-duplex 8N1 UART. TX is fed from a 2^FIFO_ADDR_BITS entry FIFO; RX
// delivers single bytes with a valid/ack handshake and a sticky overrun flag.
// Optional: define IKBD_UART_TWO_STOP_EN to stretch the TX stop bit to two
// bit times (8N2 on TX). RX accepts any stop/idle length in both builds.
module ikbd_uart #(
    parameter int CLK_DIV        = 1024,
    parameter int FIFO_ADDR_BITS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_strobe,
    output logic       tx_full,
    output logic       tx_idle,
    output logic       serial_out,
    input  logic       serial_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_overrun,
    output logic       rx_frame_err
);

    localparam int DEPTH = 1 << FIFO_ADDR_BITS;
`ifdef IKBD_UART_TWO_STOP_EN
    localparam int STOP_CYCLES = 2 * CLK_DIV;
`else
    localparam int STOP_CYCLES = CLK_DIV;
`endif
    localparam int CW = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CYCLES - 1);
    localparam logic [FIFO_ADDR_BITS:0] FIFO_FULL_CNT = (FIFO_ADDR_BITS + 1)'(DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

    tx_state_t tx_state, tx_next;
    rx_state_t rx_state, rx_next;

    logic [7:0]                fifo_mem [DEPTH];
    logic [FIFO_ADDR_BITS-1:0] wr_ptr, rd_ptr;
    logic [FIFO_ADDR_BITS:0]   fifo_count;
    logic                      fifo_empty, fifo_push, fifo_pop;

    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;

    logic          rx_sync1, rx_sync2;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_done, rx_bad;

    // A full FIFO refuses writes even when a pop happens on the same edge.
    assign tx_full    = (fifo_count == FIFO_FULL_CNT);
    assign fifo_empty = (fifo_count == '0);
    assign fifo_push  = tx_strobe && !tx_full;
    assign fifo_pop   = (tx_state == TX_IDLE) && !fifo_empty;
    assign tx_idle    = (tx_state == TX_IDLE) && fifo_empty;

    // FIFO storage; written only on accepted strobes.
    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr] <= tx_data;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // TX state register.
    always_ff @(posedge clk) begin
        if (reset) tx_state <= TX_IDLE;
        else       tx_state <= tx_next;
    end

    // TX next-state: each state ends when its bit-time counter expires.
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (!fifo_empty) tx_next = TX_START;
            TX_START: if (tx_cnt == BIT_LAST) tx_next = TX_DATA;
            TX_DATA:  if (tx_cnt == BIT_LAST && tx_bit == 3'd7) tx_next = TX_STOP;
            TX_STOP:  if (tx_cnt == STOP_LAST) tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    // TX datapath: bit timer, shift register and the registered line driver.
    always_ff @(posedge clk) begin
        if (reset) begin
            serial_out <= 1'b1;
            tx_cnt     <= '0;
            tx_bit     <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_cnt <= '0;
                    tx_bit <= '0;
                    if (fifo_pop) begin
                        tx_shift   <= fifo_mem[rd_ptr];
                        serial_out <= 1'b0;
                    end else begin
                        serial_out <= 1'b1;
                    end
                end
                TX_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt     <= '0;
                        serial_out <= tx_shift[0];
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt     <= '0;
                        tx_bit     <= tx_bit + 1'b1;
                        tx_shift   <= {1'b0, tx_shift[7:1]};
                        serial_out <= (tx_bit == 3'd7) ? 1'b1 : tx_shift[1];
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: begin
                    serial_out <= 1'b1;
                    tx_cnt     <= (tx_cnt == STOP_LAST) ? '0 : tx_cnt + 1'b1;
                end
            endcase
        end
    end

    // Two-flop synchronizer for the asynchronous RX line (idles high).
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync1 <= 1'b1;
            rx_sync2 <= 1'b1;
        end else begin
            rx_sync1 <= serial_in;
            rx_sync2 <= rx_sync1;
        end
    end

    // RX state register.
    always_ff @(posedge clk) begin
        if (reset) rx_state <= RX_IDLE;
        else       rx_state <= rx_next;
    end

    // RX next-state and stop-bit verdict; samples are taken at mid-bit.
    always_comb begin
        rx_next = rx_state;
        rx_done = 1'b0;
        rx_bad  = 1'b0;
        case (rx_state)
            RX_IDLE:  if (!rx_sync2) rx_next = RX_START;
            RX_START: if (rx_cnt == HALF_LAST) rx_next = rx_sync2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_cnt == BIT_LAST && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    if (rx_sync2) begin
                        rx_next = RX_IDLE;
                        rx_done = 1'b1;
                    end else begin
                        rx_next = RX_BREAK;
                        rx_bad  = 1'b1;
                    end
                end
            end
            RX_BREAK: if (rx_sync2) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    // RX datapath: half-bit then full-bit timing, LSB-first shift in.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_cnt <= '0;
            rx_bit <= '0;
        end else begin
            case (rx_state)
                RX_START: rx_cnt <= (rx_cnt == HALF_LAST) ? '0 : rx_cnt + 1'b1;
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= rx_bit + 1'b1;
                        rx_shift <= {rx_sync2, rx_shift[7:1]};
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: rx_cnt <= (rx_cnt == BIT_LAST) ? '0 : rx_cnt + 1'b1;
                default: begin
                    rx_cnt <= '0;
                    rx_bit <= '0;
                end
            endcase
        end
    end

    // Consumer handshake: an ack frees the holding register in the same edge
    // a new byte lands; otherwise a new byte against a full holder is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_frame_err <= rx_bad;
            if (rx_done && (!rx_valid || rx_ack)) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
            if (rx_ack)                   rx_overrun <= 1'b0;
            else if (rx_done && rx_valid) rx_overrun <= 1'b1;
        end
    end

endmodule

// File: doc/ikbd_uart.md
Name: ikbd_uart

Overview:
- Keyboard-controller end of the IKBD serial link: full-duplex 8N1 UART for the soft IKBD core.
- TX carries bytes from the IKBD logic (scancodes, mouse packets) to the ST-side 6850 ACIA. RX carries ACIA command bytes to the IKBD logic.
- Line rate is 7812.5 bit/s from the 8 MHz system clock (1024 clocks per bit). TX has a 16-entry FIFO so packet bursts can be queued.

Parameters:
- CLK_DIV, 1024, system clocks per bit time; must be an even number ≥ 8 (benches use 16).
- FIFO_ADDR_BITS, 4, log2 of TX FIFO depth (default 16 entries).

Ports:
- clk  in  1  system clock, 8 MHz, all logic on the rising edge
- reset  in  1  synchronous, active-high
- tx_data  in  8  byte to queue for transmission
- tx_strobe  in  1  one-cycle pulse; writes tx_data into the FIFO
- tx_full  out  1  FIFO holds 2^FIFO_ADDR_BITS entries
- tx_idle  out  1  FIFO empty and transmitter in IDLE
- serial_out  out  1  TX line to the ACIA RX; idle high
- serial_in  in  1  RX line from the ACIA TX; asynchronous, idle high
- rx_data  out  8  last received byte
- rx_valid  out  1  rx_data holds an unconsumed byte
- rx_ack  in  1  one-cycle pulse; consumer has taken rx_data
- rx_overrun  out  1  sticky; a byte was dropped while rx_valid=1
- rx_frame_err  out  1  one-cycle pulse on a bad stop bit

Behaviour:
- Reset values: serial_out=1, tx_full=0, tx_idle=1, rx_data=0, rx_valid=0, rx_overrun=0, rx_frame_err=0. FIFO pointers are cleared and both FSMs go to IDLE.
- Reset asserted mid-frame aborts the frame immediately. serial_out is 1 in the cycle after the reset edge, and queued bytes are lost.
- TX FIFO:
  - tx_strobe with the FIFO not full writes the byte. tx_strobe with the FIFO full drops the byte silently; this holds even if a pop occurs in the same cycle.
  - Write and pop in the same cycle on a non-full FIFO leaves the count unchanged. Pointers wrap modulo depth.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: if the FIFO is non-empty, pop the head into a shift register and enter START on the same edge.
  - START: serial_out=0 for CLK_DIV cycles.
  - DATA: 8 bits LSB first, CLK_DIV cycles each.
  - STOP: serial_out=1 for CLK_DIV cycles. Then IDLE, which can pop the next byte on its first cycle. Back-to-back frames therefore have exactly 1 idle cycle between the stop bit and the next start bit.
  - serial_out is registered.
- RX front end: serial_in passes through a 2-FF synchronizer; all RX decisions use the synchronized value.
- RX FSM: IDLE -> START -> DATA -> STOP -> (IDLE | BREAK).
  - IDLE: synchronized low starts a counter of CLK_DIV/2 and enters START.
  - START: at mid-bit, if the line is high it is a false start -> IDLE; otherwise -> DATA.
  - DATA: sample every CLK_DIV cycles, 8 bits, shift in LSB first.
  - STOP: sample at mid-bit.
    - High: rx_data is loaded, rx_valid=1, state -> IDLE.
    - Low: rx_frame_err pulses for one cycle, the byte is discarded, state -> BREAK.
  - BREAK: wait for a synchronized high, then IDLE.
- RX handshake and overrun:
  - rx_ack clears rx_valid on the next edge.
  - A byte completes while rx_valid=1 and rx_ack=0: old rx_data is kept, the new byte is dropped, rx_overrun is set.
  - A byte completes in the same cycle as rx_ack: the new byte is loaded, rx_valid stays 1, no overrun.
  - rx_overrun is cleared by rx_ack or reset.
- tx_idle and tx_full are combinational from the FIFO count and TX state.

Optional Feature:
- Macro IKBD_UART_TWO_STOP_EN.
- Defined: the TX STOP state lasts 2*CLK_DIV cycles (8N2 on TX), giving the host extra inter-byte gap. This gap is required by some ST software.
- Undefined: 1 stop bit. RX is unaffected in both cases and accepts any idle length.

Test Plan:
- CLK_DIV=16, tx_strobe with 0xA5 -> serial_out low 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, then high 16 cycles. tx_idle=1 on the cycle after STOP.
- serial_in driven with a 16-cycle-per-bit frame of 0x3C -> rx_valid=1 with rx_data=0x3C. rx_ack -> rx_valid=0 on the next cycle.
- serial_in low for 4 cycles, then high -> no rx_valid and no rx_frame_err; the next valid frame 0x12 is received correctly.
- Frame 0x55 with stop bit low, line held low 40 cycles then high -> exactly one rx_frame_err pulse and rx_valid=0. The following frame 0x81 is received.
- Frames 0x11 then 0x22 with no rx_ack -> rx_data=0x11 and rx_overrun=1; rx_ack clears both rx_valid and rx_overrun.
- 18 tx_strobe pulses on consecutive cycles (bytes 0..17), FIFO depth 16 -> tx_full=1 from cycle 17. Bytes 0..16 are sent in order; byte 17 is never transmitted.
- Reset mid-frame -> serial_out=1 on the next cycle and tx_idle=1.
